data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 144 ++++++++++++++
 tb/tb_data_mem_responder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data memory responder: word array fronted by a small FIFO store buffer.
// Stores are queued and retired into the array during idle cycles, or
// whenever the buffer is full. Loads see the array word merged with every
// pending buffered store to the same word, so buffering is invisible to reads.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int SB_DEPTH   = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [31:0]                data_address_2DM,
  input  logic [31:0]                data_write_2DM,
  input  logic [1:0]                 data_write_size_2DM,
  input  logic                       MemRead_2DM,
  input  logic                       MemWrite_2DM,
  output logic [31:0]                data_read_fDM,
  output logic [$clog2(SB_DEPTH):0]  sb_count
);

  localparam int PW    = $clog2(SB_DEPTH);
  localparam int WORDS = 2 ** ADDR_WIDTH;
  localparam logic [PW:0] SB_FULL = SB_DEPTH[PW:0];

  logic [31:0]           mem_q    [WORDS];
  logic [ADDR_WIDTH-1:0] sbIdx_q  [SB_DEPTH];
  logic [3:0]            sbMask_q [SB_DEPTH];
  logic [31:0]           sbData_q [SB_DEPTH];

  logic [PW-1:0] sbHead_q, sbHead_d;
  logic [PW-1:0] sbTail_q, sbTail_d;
  logic [PW:0]   sbCount_q, sbCount_d;

  logic [ADDR_WIDTH-1:0] wordIdx;
  logic [1:0]            byteOff;
  logic [3:0]            storeMask;
  logic [31:0]           storeData;
  logic [2:0]            lane;
  logic [1:0]            lanePos;
  logic [1:0]            srcByte;
  logic [PW-1:0]         slot;
  logic [31:0]           readWord;
  logic                  enqueue;
  logic                  drain;
  logic                  unusedAddrBits;

  // Address bits above the word index alias; they are deliberately dropped.
  assign wordIdx        = data_address_2DM[ADDR_WIDTH+1:2];
  assign byteOff        = data_address_2DM[1:0];
  assign unusedAddrBits = ^data_address_2DM[31:ADDR_WIDTH+2];

  assign enqueue  = MemWrite_2DM;
  assign drain    = (sbCount_q != '0) &&
                    ((!MemRead_2DM && !MemWrite_2DM) || (sbCount_q == SB_FULL));
  assign sb_count = sbCount_q;

  // Position the store bytes into big-endian lanes; lanes past offset 3 are clipped.
  always_comb begin
    storeMask = 4'b0000;
    storeData = 32'h0;
    lane      = 3'd0;
    lanePos   = 2'd0;
    srcByte   = 2'd0;
    if (data_write_size_2DM == 2'd0) begin
      storeMask = 4'b1111;
      storeData = data_write_2DM;
    end else begin
      for (int j = 0; j < 3; j++) begin
        lane = {1'b0, byteOff} + 3'(j);
        if ((3'(j) < {1'b0, data_write_size_2DM}) && (lane <= 3'd3)) begin
          lanePos = 2'd3 - lane[1:0];
          srcByte = data_write_size_2DM - 2'd1 - 2'(j);
          storeMask[lanePos] = 1'b1;
          storeData[{lanePos, 3'b000} +: 8] = data_write_2DM[{srcByte, 3'b000} +: 8];
        end
      end
    end
  end

  // Advance FIFO pointers and occupancy; full-with-store always drains, so count caps at depth.
  always_comb begin
    sbHead_d  = sbHead_q;
    sbTail_d  = sbTail_q;
    sbCount_d = sbCount_q;
    if (enqueue) sbTail_d = sbTail_q + 1'b1;
    if (drain)   sbHead_d = sbHead_q + 1'b1;
    case ({enqueue, drain})
      2'b10:   sbCount_d = sbCount_q + 1'b1;
      2'b01:   sbCount_d = sbCount_q - 1'b1;
      default: sbCount_d = sbCount_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the buffer and discards pending stores.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sbHead_q  <= '0;
      sbTail_q  <= '0;
      sbCount_q <= '0;
    end else begin
      sbHead_q  <= sbHead_d;
      sbTail_q  <= sbTail_d;
      sbCount_q <= sbCount_d;
    end
  end

  // Capture an incoming store at the tail slot; validity is tracked by the pointers alone.
  always_ff @(posedge CLK) begin
    if (enqueue) begin
      sbIdx_q[sbTail_q]  <= wordIdx;
      sbMask_q[sbTail_q] <= storeMask;
      sbData_q[sbTail_q] <= storeData;
    end
  end

  // Retire the head entry into the array, touching only its masked lanes.
  always_ff @(posedge CLK) begin
    if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (sbMask_q[sbHead_q][b]) begin
          mem_q[sbIdx_q[sbHead_q]][8*b +: 8] <= sbData_q[sbHead_q][8*b +: 8];
        end
      end
    end
  end

  // Read path: array word overlaid by pending stores, oldest first so the youngest wins.
  always_comb begin
    readWord = mem_q[wordIdx];
    slot     = sbHead_q;
    for (int k = 0; k < SB_DEPTH; k++) begin
      slot = sbHead_q + PW'(k);
      if ((k < int'(sbCount_q)) && (sbIdx_q[slot] == wordIdx)) begin
        for (int b = 0; b < 4; b++) begin
          if (sbMask_q[slot][b]) begin
            readWord[8*b +: 8] = sbData_q[slot][8*b +: 8];
          end
        end
      end
    end
  end

  assign data_read_fDM = readWord;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: byte stores, clipping, FIFO
// fill/drain, youngest-wins forwarding, same-cycle read/write, async reset.
module tb_data_mem_responder;

  logic        CLK;
  logic        RESET;
  logic [31:0] data_address_2DM;
  logic [31:0] data_write_2DM;
  logic [1:0]  data_write_size_2DM;
  logic        MemRead_2DM;
  logic        MemWrite_2DM;
  logic [31:0] data_read_fDM;
  logic [2:0]  sb_count;

  int compared;
  int mismatched;

  data_mem_responder dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .data_address_2DM    (data_address_2DM),
    .data_write_2DM      (data_write_2DM),
    .data_write_size_2DM (data_write_size_2DM),
    .MemRead_2DM         (MemRead_2DM),
    .MemWrite_2DM        (MemWrite_2DM),
    .data_read_fDM       (data_read_fDM),
    .sb_count            (sb_count)
  );

  // Free-running 10 ns clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [1:0] size);
    MemRead_2DM         = rd;
    MemWrite_2DM        = wr;
    data_address_2DM    = addr;
    data_write_2DM      = data;
    data_write_size_2DM = size;
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic seedWord(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b0, 1'b1, addr, data, 2'd0);
    step();
    applyStimulus(1'b0, 1'b0, addr, 32'h0, 2'd0);
    step();
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    #3 RESET = 1'b0;
    #1;
    compared++;
    if (sb_count !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_count: got %0d expected 0", sb_count);
    end
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    step();
    compared++;
    if (sb_count !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_release_count: got %0d expected 0", sb_count);
    end
  endtask

  task automatic test_byte_store;
    seedWord(32'h14, 32'h11223344);
    compared++;
    if (data_read_fDM !== 32'h11223344) begin
      mismatched++;
      $display("[TB] FAIL seed_word5: got %h expected 11223344", data_read_fDM);
    end
    applyStimulus(1'b0, 1'b1, 32'h15, 32'h000000AA, 2'd1);
    step();
    applyStimulus(1'b0, 1'b0, 32'h14, 32'h0, 2'd0);
    #1;
    compared++;
    if (sb_count !== 3'd1) begin
      mismatched++;
      $display("[TB] FAIL byte_count_buffered: got %0d expected 1", sb_count);
    end
    compared++;
    if (data_read_fDM !== 32'h11AA3344) begin
      mismatched++;
      $display("[TB] FAIL byte_forward: got %h expected 11AA3344", data_read_fDM);
    end
    step();
    compared++;
    if (sb_count !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL byte_count_drained: got %0d expected 0", sb_count);
    end
    compared++;
    if (data_read_fDM !== 32'h11AA3344) begin
      mismatched++;
      $display("[TB] FAIL byte_array: got %h expected 11AA3344", data_read_fDM);
    end
  endtask

  task automatic test_clip;
    seedWord(32'h20, 32'h00000000);
    applyStimulus(1'b0, 1'b1, 32'h21, 32'h00ABCDEF, 2'd3);
    step();
    applyStimulus(1'b0, 1'b1, 32'h22, 32'h00123456, 2'd3);
    #2;
    compared++;
    if (data_read_fDM !== 32'h00ABCDEF) begin
      mismatched++;
      $display("[TB] FAIL clip_first: got %h expected 00ABCDEF", data_read_fDM);
    end
    step();
    applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 2'd0);
    #1;
    compared++;
    if (sb_count !== 3'd2) begin
      mismatched++;
      $display("[TB] FAIL clip_count: got %0d expected 2", sb_count);
    end
    compared++;
    if (data_read_fDM !== 32'h00AB1234) begin
      mismatched++;
      $display("[TB] FAIL clip_forward: got %h expected 00AB1234", data_read_fDM);
    end
    step();
    compared++;
    if (data_read_fDM !== 32'h00AB1234) begin
      mismatched++;
      $display("[TB] FAIL clip_half_drained: got %h expected 00AB1234", data_read_fDM);
    end
    step();
    compared++;
    if ((sb_count !== 3'd0) || (data_read_fDM !== 32'h00AB1234)) begin
      mismatched++;
      $display("[TB] FAIL clip_drained: got count %0d word %h expected 0 00AB1234",
               sb_count, data_read_fDM);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] expCount [5];
    expCount[0] = 3'd1;
    expCount[1] = 3'd2;
    expCount[2] = 3'd3;
    expCount[3] = 3'd4;
    expCount[4] = 3'd4;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 32'(4 * i), 32'(i + 1), 2'd0);
      step();
      compared++;
      if (sb_count !== expCount[i]) begin
        mismatched++;
        $display("[TB] FAIL b2b_count[%0d]: got %0d expected %0d", i, sb_count, expCount[i]);
      end
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    #1;
    compared++;
    if (data_read_fDM !== 32'd1) begin
      mismatched++;
      $display("[TB] FAIL b2b_word0_drained: got %h expected 00000001", data_read_fDM);
    end
    data_address_2DM = 32'h10;
    #1;
    compared++;
    if (data_read_fDM !== 32'd5) begin
      mismatched++;
      $display("[TB] FAIL b2b_word4_forward: got %h expected 00000005", data_read_fDM);
    end
    for (int i = 0; i < 4; i++) step();
    compared++;
    if (sb_count !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL b2b_empty: got %0d expected 0", sb_count);
    end
    for (int i = 0; i < 5; i++) begin
      data_address_2DM = 32'(4 * i);
      #1;
      compared++;
      if (data_read_fDM !== 32'(i + 1)) begin
        mismatched++;
        $display("[TB] FAIL b2b_array[%0d]: got %h expected %h", i, data_read_fDM, 32'(i + 1));
      end
    end
  endtask

  task automatic test_youngest_wins;
    applyStimulus(1'b0, 1'b1, 32'h0C, 32'hDEADBEEF, 2'd0);
    step();
    applyStimulus(1'b0, 1'b1, 32'h0C, 32'h00001234, 2'd2);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0C, 32'h0, 2'd0);
    #1;
    compared++;
    if ((sb_count !== 3'd2) || (data_read_fDM !== 32'h1234BEEF)) begin
      mismatched++;
      $display("[TB] FAIL youngest_forward: got count %0d word %h expected 2 1234BEEF",
               sb_count, data_read_fDM);
    end
    step();
    step();
    compared++;
    if ((sb_count !== 3'd0) || (data_read_fDM !== 32'h1234BEEF)) begin
      mismatched++;
      $display("[TB] FAIL youngest_drained: got count %0d word %h expected 0 1234BEEF",
               sb_count, data_read_fDM);
    end
  endtask

  task automatic test_read_write_same_cycle;
    seedWord(32'h40, 32'h00000000);
    applyStimulus(1'b1, 1'b1, 32'h40, 32'h77777777, 2'd0);
    #2;
    compared++;
    if (data_read_fDM !== 32'h00000000) begin
      mismatched++;
      $display("[TB] FAIL rw_same_cycle: got %h expected 00000000", data_read_fDM);
    end
    step();
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 2'd0);
    #1;
    compared++;
    if ((sb_count !== 3'd1) || (data_read_fDM !== 32'h77777777)) begin
      mismatched++;
      $display("[TB] FAIL rw_next_cycle: got count %0d word %h expected 1 77777777",
               sb_count, data_read_fDM);
    end
    step();
    compared++;
    if (sb_count !== 3'd1) begin
      mismatched++;
      $display("[TB] FAIL rw_load_holds: got %0d expected 1", sb_count);
    end
    applyStimulus(1'b0, 1'b0, 32'h40, 32'h0, 2'd0);
    step();
    compared++;
    if ((sb_count !== 3'd0) || (data_read_fDM !== 32'h77777777)) begin
      mismatched++;
      $display("[TB] FAIL rw_drained: got count %0d word %h expected 0 77777777",
               sb_count, data_read_fDM);
    end
  endtask

  task automatic test_reset_mid_burst;
    logic [31:0] seeds [3];
    seeds[0] = 32'h0A0A0A0A;
    seeds[1] = 32'h0B0B0B0B;
    seeds[2] = 32'h0C0C0C0C;
    for (int i = 0; i < 3; i++) seedWord(32'h50 + 32'(4 * i), seeds[i]);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h50 + 32'(4 * i), 32'hFFFFFFFF, 2'd0);
      step();
    end
    applyStimulus(1'b0, 1'b0, 32'h54, 32'h0, 2'd0);
    #1;
    compared++;
    if ((sb_count !== 3'd3) || (data_read_fDM !== 32'hFFFFFFFF)) begin
      mismatched++;
      $display("[TB] FAIL burst_before_reset: got count %0d word %h expected 3 FFFFFFFF",
               sb_count, data_read_fDM);
    end
    RESET = 1'b0;
    #1;
    compared++;
    if (sb_count !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL burst_async_clear: got %0d expected 0", sb_count);
    end
    step();
    @(negedge CLK);
    RESET = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      data_address_2DM = 32'h50 + 32'(4 * i);
      #1;
      compared++;
      if ((sb_count !== 3'd0) || (data_read_fDM !== seeds[i])) begin
        mismatched++;
        $display("[TB] FAIL burst_after_reset[%0d]: got count %0d word %h expected 0 %h",
                 i, sb_count, data_read_fDM, seeds[i]);
      end
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_byte_store();
    test_clip();
    test_back_to_back();
    test_youngest_wins();
    test_read_write_same_cycle();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
